cpu_program_sequencer: RTL and testbench

CPU_PROGRAM_SEQUENCER -- requirements
Module: cpu_program_sequencer

---
 rtl/cpu_seq_pkg.sv | 44 ++++
 rtl/seq_program_mem.sv | 25 ++
 rtl/cpu_program_sequencer.sv | 158 +++++++++++++++
 tb/tb_cpu_program_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU program sequencer: FSM state encoding,
// CPU opcode constants and the layout of a 12-bit program word.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GAP   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_SHL   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Program word = {opcode, data, addr}, four bits each
    localparam int WORD_W     = 12;
    localparam int OPC_LSB    = 8;
    localparam int DATA_LSB   = 4;
    localparam int ADDR_LSB   = 0;
    localparam int PROG_DEPTH = 16;

    function automatic logic [3:0] word_opcode(input logic [WORD_W-1:0] w);
        return w[OPC_LSB +: 4];
    endfunction

    function automatic logic [3:0] word_data(input logic [WORD_W-1:0] w);
        return w[DATA_LSB +: 4];
    endfunction

    function automatic logic [3:0] word_addr(input logic [WORD_W-1:0] w);
        return w[ADDR_LSB +: 4];
    endfunction

endpackage

// File: rtl/seq_program_mem.sv
// 16 x 12 program store: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; the word count qualifies them.
module seq_program_mem
    import cpu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [3:0]        raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [PROG_DEPTH];

    // Write the offered word into the addressed entry
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_program_sequencer.sv
// Loads up to 16 program words, then replays them to a CPU: each word is
// held for HOLD_CYCLES cycles followed by GAP_CYCLES cycles of NOP, with
// optional single-stepping, HALT detection, abort and clear.
module cpu_program_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_word,
    output logic              load_ready,
    input  logic              run,
    input  logic              clear,
    input  logic              abort,
    input  logic              step_mode,
    input  logic              step,
    output logic [3:0]        cpu_opcode,
    output logic [3:0]        cpu_data,
    output logic [3:0]        cpu_addr,
    output logic              cpu_we,
    output logic [3:0]        pc,
    output logic              busy,
    output logic              done
);

    // Terminal values of the shared hold/gap counter
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    seq_state_t        state;
    logic [4:0]        count;
    logic [3:0]        cnt;
    logic [WORD_W-1:0] cur_word;
    logic              wr_en;
    logic [4:0]        count_after_wr;
    logic              last_word;
    seq_state_t        gap_next;
    logic              issuing;

    // A word is stored only in LOAD, with room left, and when clear is not winning
    assign wr_en          = (state == ST_LOAD) && !clear && load_valid && !count[4];
    assign count_after_wr = count + {4'd0, wr_en};
    assign last_word      = (({1'b0, pc} + 5'd1) == count);
    assign gap_next       = last_word ? ST_DONE : (step_mode ? ST_WAIT : ST_ISSUE);

    seq_program_mem u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count[3:0]),
        .wdata (load_word),
        .raddr (pc),
        .rdata (cur_word)
    );

    // Sequencer FSM: program count, program counter and hold/gap timing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
            count <= 5'd0;
            pc    <= 4'd0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (clear) begin
                        count <= 5'd0;
                    end else begin
                        count <= count_after_wr;
                        if (run && (count_after_wr != 5'd0)) begin
                            state <= ST_ISSUE;
                            pc    <= 4'd0;
                            cnt   <= 4'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state <= ST_LOAD;
                        pc    <= 4'd0;
                        cnt   <= 4'd0;
                    end else if (word_opcode(cur_word) == OP_HALT) begin
                        state <= ST_DONE;
                    end else if (cnt == HOLD_LAST) begin
                        cnt <= 4'd0;
                        if (GAP_CYCLES == 0) begin
                            state <= gap_next;
                            if (!last_word) pc <= pc + 4'd1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state <= ST_LOAD;
                        pc    <= 4'd0;
                        cnt   <= 4'd0;
                    end else if (cnt == GAP_LAST) begin
                        cnt   <= 4'd0;
                        state <= gap_next;
                        if (!last_word) pc <= pc + 4'd1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_LOAD;
                        pc    <= 4'd0;
                        cnt   <= 4'd0;
                    end else if (step || !step_mode) begin
                        state <= ST_ISSUE;
                        cnt   <= 4'd0;
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state <= ST_LOAD;
                        pc    <= 4'd0;
                        cnt   <= 4'd0;
                    end else if (clear) begin
                        state <= ST_LOAD;
                        count <= 5'd0;
                        pc    <= 4'd0;
                    end else if (run) begin
                        state <= ST_ISSUE;
                        pc    <= 4'd0;
                        cnt   <= 4'd0;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                    count <= 5'd0;
                    pc    <= 4'd0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // CPU-facing outputs decode from registered state only; HALT is never driven
    always_comb begin
        issuing    = (state == ST_ISSUE) && (word_opcode(cur_word) != OP_HALT);
        cpu_opcode = issuing ? word_opcode(cur_word) : OP_NOP;
        cpu_data   = issuing ? word_data(cur_word) : 4'd0;
        cpu_addr   = issuing ? word_addr(cur_word) : 4'd0;
        cpu_we     = issuing && (word_opcode(cur_word) == OP_STORE);
        load_ready = (state == ST_LOAD) && !count[4];
        busy       = (state == ST_ISSUE) || (state == ST_GAP) || (state == ST_WAIT);
        done       = (state == ST_DONE);
    end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Self-checking bench for cpu_program_sequencer. A schedule model turns the
// loaded program into the expected per-cycle output sequence; a compare
// process checks every cycle, and directed literals pin the model.
module tb_cpu_program_sequencer;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [11:0] load_word = 12'd0;
    logic        load_ready;
    logic        run = 1'b0, clear = 1'b0, abort = 1'b0;
    logic        step_mode = 1'b0, step = 1'b0;
    logic [3:0]  cpu_opcode, cpu_data, cpu_addr, pc;
    logic        cpu_we, busy, done;

    cpu_program_sequencer #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_word  (load_word),
        .load_ready (load_ready),
        .run        (run),
        .clear      (clear),
        .abort      (abort),
        .step_mode  (step_mode),
        .step       (step),
        .cpu_opcode (cpu_opcode),
        .cpu_data   (cpu_data),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] data;
        logic [3:0] addr;
        logic       we;
        logic       busy;
        logic       done;
        logic       ready;
        logic [3:0] pc;
    } exp_t;

    // Model state
    logic [11:0] m_prog [16];
    int          m_count   = 0;
    bit          rest_done = 0;
    logic [3:0]  rest_pc   = 4'd0;
    exp_t        sched[$];
    exp_t        exp_cur;
    bit          chk_en = 0;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [3:0] d,
                                input logic [3:0] a, input logic we,
                                input logic [3:0] p);
        exp_t e;
        e.op = op; e.data = d; e.addr = a; e.we = we;
        e.busy = 1'b1; e.done = 1'b0; e.ready = 1'b0; e.pc = p;
        return e;
    endfunction

    // Outputs when no execution is scheduled: idle in LOAD or parked in DONE
    function automatic exp_t rest_entry();
        exp_t e;
        e.op = 4'hE; e.data = 4'd0; e.addr = 4'd0; e.we = 1'b0; e.busy = 1'b0;
        e.done  = rest_done;
        e.ready = !rest_done && (m_count < 16);
        e.pc    = rest_done ? rest_pc : 4'd0;
        return e;
    endfunction

    // Expand the program into its cycle-by-cycle output sequence
    task automatic model_run(input int wait_n);
        logic [11:0] w;
        if (m_count == 0) return;
        sched.delete();
        rest_done = 0;
        for (int i = 0; i < m_count; i++) begin
            w = m_prog[i];
            if (w[11:8] == 4'hF) begin
                sched.push_back(mk(4'hE, 4'd0, 4'd0, 1'b0, 4'(i)));
                rest_done = 1; rest_pc = 4'(i);
                return;
            end
            for (int h = 0; h < HOLD; h++)
                sched.push_back(mk(w[11:8], w[7:4], w[3:0], w[11:8] == 4'h2, 4'(i)));
            for (int g = 0; g < GAP; g++)
                sched.push_back(mk(4'hE, 4'd0, 4'd0, 1'b0, 4'(i)));
            if (i == m_count - 1) begin
                rest_done = 1; rest_pc = 4'(i);
                return;
            end
            for (int k = 0; k < wait_n; k++)
                sched.push_back(mk(4'hE, 4'd0, 4'd0, 1'b0, 4'(i + 1)));
        end
    endtask

    task automatic model_load(input logic [11:0] w);
        if (m_count < 16) begin
            m_prog[m_count] = w;
            m_count++;
        end
    endtask

    task automatic model_to_load();
        sched.delete();
        rest_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (sched.size() > 0) exp_cur = sched.pop_front();
        else exp_cur = rest_entry();
        #1;
    endtask

    task automatic do_load(input logic [11:0] w);
        load_valid = 1'b1; load_word = w; model_load(w);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_run(input int wait_n);
        run = 1'b1; model_run(wait_n);
        tick();
        run = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; model_to_load();
        tick();
        abort = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; m_count = 0; model_to_load();
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; m_count = 0; model_to_load();
        tick();
        rst = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_opcode", int'(cpu_opcode), int'(exp_cur.op));
            check("cpu_data",   int'(cpu_data),   int'(exp_cur.data));
            check("cpu_addr",   int'(cpu_addr),   int'(exp_cur.addr));
            check("cpu_we",     int'(cpu_we),     int'(exp_cur.we));
            check("busy",       int'(busy),       int'(exp_cur.busy));
            check("done",       int'(done),       int'(exp_cur.done));
            check("load_ready", int'(load_ready), int'(exp_cur.ready));
            check("pc",         int'(pc),         int'(exp_cur.pc));
        end
    end

    logic [3:0] ops [9];
    int n, we_first, we_cnt;

    initial begin
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        exp_cur = rest_entry();

        // Reset
        do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        chk_en = 1;
        tick();
        check("lit_reset_ready", int'(load_ready), 1);
        check("lit_reset_busy", int'(busy), 0);
        check("lit_reset_opcode", int'(cpu_opcode), 14);

        // Three-word program: 4 hold + 2 gap each, STORE in the third, done at 18
        do_load(12'h305);
        do_load(12'h030);
        do_load(12'h206);
        do_run(0);
        check("lit_first_opcode", int'(cpu_opcode), 3);
        check("lit_first_addr", int'(cpu_addr), 5);
        n = 0; we_first = -1; we_cnt = 0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (cpu_we) begin
                we_cnt++;
                if (we_first < 0) we_first = n;
            end
        end
        check("lit_done_cycles", n, 18);
        check("lit_we_first", we_first, 12);
        check("lit_we_cycles", we_cnt, 4);
        check("lit_done_pc", int'(pc), 2);
        repeat (2) tick();

        // Rerun from DONE, then abort during ISSUE of pc = 1
        do_run(0);
        check("lit_rerun_pc", int'(pc), 0);
        repeat (7) tick();
        check("lit_pc1_issue", int'(pc), 1);
        do_abort();
        check("lit_abort_busy", int'(busy), 0);
        check("lit_abort_pc", int'(pc), 0);
        check("lit_abort_opcode", int'(cpu_opcode), 14);
        do_run(0);
        check("lit_restart_opcode", int'(cpu_opcode), 3);

        // Reset in the middle of a gap discards the program
        repeat (4) tick();
        check("lit_in_gap", int'(cpu_opcode), 14);
        do_reset();
        check("lit_rst_busy", int'(busy), 0);
        check("lit_rst_ready", int'(load_ready), 1);
        do_run(0);
        check("lit_empty_run_busy", int'(busy), 0);
        tick();

        // HALT as word 1: done one edge after entering ISSUE at pc = 1
        do_load(12'h305);
        do_load(12'hF00);
        do_load(12'h030);
        do_run(0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("lit_halt_cycles", n, 7);
        check("lit_halt_pc", int'(pc), 1);
        tick();

        // Clear from DONE, then clear beats a simultaneous load offer
        do_clear();
        clear = 1'b1; load_valid = 1'b1; load_word = 12'h111;
        tick();
        clear = 1'b0; load_valid = 1'b0;
        do_run(0);
        check("lit_clear_run_busy", int'(busy), 0);

        // Load and run in the same cycle with an empty program
        load_valid = 1'b1; run = 1'b1; load_word = 12'h5A7;
        model_load(12'h5A7); model_run(0);
        tick();
        load_valid = 1'b0; run = 1'b0;
        check("lit_loadrun_opcode", int'(cpu_opcode), 5);
        repeat (8) tick();
        do_abort();
        do_clear();

        // Step mode: WAIT holds NOP until the step pulse
        do_load(12'h1C3);
        do_load(12'h2AB);
        step_mode = 1'b1;
        do_run(3);
        repeat (8) tick();
        check("lit_wait_opcode", int'(cpu_opcode), 14);
        check("lit_wait_busy", int'(busy), 1);
        check("lit_wait_pc", int'(pc), 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("lit_step_opcode", int'(cpu_opcode), 2);
        check("lit_step_addr", int'(cpu_addr), 11);
        check("lit_step_we", int'(cpu_we), 1);
        step_mode = 1'b0;
        repeat (8) tick();
        do_clear();

        // Full program store: 17th offer ignored, pc runs to 15
        for (int i = 0; i < 16; i++)
            do_load({ops[i % 9], 4'(i), 4'(15 - i)});
        check("lit_full_ready", int'(load_ready), 0);
        do_load(12'h0FF);
        do_run(0);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("lit_full_cycles", n, 96);
        check("lit_full_pc", int'(pc), 15);
        tick();

        chk_en = 0;
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
